// File: rtl/dmem_unit.sv
// Byte-addressed Y86 data memory: 32-bit little-endian words, self-clearing after reset,
// access error flagging and saturating access counters. Optional macro: DMEM_ALIGN_CHECK_EN.
module dmem_unit #(
    parameter int unsigned DEPTH_BYTES = 1024,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_data,
    output logic [31:0]      valM_o,
    output logic             dmem_error,
    output logic             busy,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] wr_count
);

    localparam int unsigned AW = $clog2(DEPTH_BYTES);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH_BYTES - 4);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   clr_ptr;
    logic [7:0]      mem [DEPTH_BYTES];

    logic            is_clear;
    logic            is_ready;
    logic            addr_valid;
    logic            align_err;
    logic            conflict;
    logic            rd_acc;
    logic            wr_acc;
    logic            mem_we;
    logic [AW-1:0]   wr_base;
    logic [31:0]     wr_word;
    logic [AW-1:0]   rd_base;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: leave CLEAR on the cycle that zeroes the last word
    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (clr_ptr == LAST_PTR) state_nxt = READY;
            READY:   state_nxt = READY;
            default: state_nxt = CLEAR;
        endcase
    end

    // FSM outputs
    always_comb begin
        is_clear = 1'b0;
        is_ready = 1'b0;
        case (state)
            CLEAR:   is_clear = 1'b1;
            READY:   is_ready = 1'b1;
            default: is_clear = 1'b1;
        endcase
        busy = is_clear;
    end

    // Clear pointer advances one word per CLEAR cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_ptr <= '0;
        end else if (is_clear) begin
            clr_ptr <= clr_ptr + AW'(4);
        end
    end

    // Access qualification; 33-bit compare keeps top-of-space addresses from wrapping
    always_comb begin
        addr_valid = ({1'b0, mem_addr} + 33'd3) < 33'(DEPTH_BYTES);
`ifdef DMEM_ALIGN_CHECK_EN
        align_err  = (mem_addr[1:0] != 2'b00);
`else
        align_err  = 1'b0;
`endif
        conflict   = mem_read && mem_write;
        dmem_error = is_ready && (mem_read || mem_write) && (!addr_valid || conflict || align_err);
        rd_acc     = is_ready && mem_read && !mem_write && addr_valid && !align_err;
        wr_acc     = is_ready && mem_write && !mem_read && addr_valid && !align_err;
    end

    // Shared write port: clear sequencer or accepted store; reset blocks both
    always_comb begin
        mem_we  = !rst && (is_clear || wr_acc);
        wr_base = is_clear ? clr_ptr : mem_addr[AW-1:0];
        wr_word = is_clear ? 32'h0 : mem_data;
        rd_base = mem_addr[AW-1:0];
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < 4; k++) begin
                mem[wr_base + AW'(k)] <= wr_word[8*k +: 8];
            end
        end
    end

    // Zero-latency read; returns pre-edge contents, zero unless a read is accepted
    always_comb begin
        valM_o = 32'h0;
        if (rd_acc) begin
            valM_o = {mem[rd_base + AW'(3)], mem[rd_base + AW'(2)],
                      mem[rd_base + AW'(1)], mem[rd_base]};
        end
    end

    // Saturating access counters
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (rd_acc && (rd_count != {CNT_W{1'b1}})) begin
                rd_count <= rd_count + CNT_W'(1);
            end
            if (wr_acc && (wr_count != {CNT_W{1'b1}})) begin
                wr_count <= wr_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dmem_unit.sv
// Bench for dmem_unit: byte-array reference model checked every cycle plus directed literal checks.
module tb_dmem_unit;

    localparam int unsigned DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [31:0] valM_o;
    logic        dmem_error;
    logic        busy;
    logic [31:0] rd_count;
    logic [31:0] wr_count;

    always #5 clk = ~clk;

    dmem_unit #(.DEPTH_BYTES(DEPTH), .CNT_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .valM_o     (valM_o),
        .dmem_error (dmem_error),
        .busy       (busy),
        .rd_count   (rd_count),
        .wr_count   (wr_count)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain byte array, clear modelled as a countdown of remaining busy cycles
    logic [7:0]  m_mem [DEPTH];
    bit          known = 1'b0;
    int          clear_left = 0;
    logic [31:0] m_rd = 32'h0;
    logic [31:0] m_wr = 32'h0;

    function automatic bit m_valid(input logic [31:0] a);
        return (64'(a) + 64'd3) < 64'(DEPTH);
    endfunction

    function automatic bit m_align(input logic [31:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
        return a[1:0] != 2'b00;
`else
        return (a & 32'h0) != 32'h0;
`endif
    endfunction

    function automatic logic [31:0] m_word(input logic [31:0] a);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = m_mem[int'(a) + k];
        return w;
    endfunction

    function automatic bit m_ready();
        return known && (clear_left == 0);
    endfunction

    function automatic bit m_rd_ok();
        return m_ready() && mem_read && !mem_write && m_valid(mem_addr) && !m_align(mem_addr);
    endfunction

    function automatic bit m_wr_ok();
        return m_ready() && mem_write && !mem_read && m_valid(mem_addr) && !m_align(mem_addr);
    endfunction

    function automatic bit m_err();
        return m_ready() && (mem_read || mem_write) &&
               (!m_valid(mem_addr) || (mem_read && mem_write) || m_align(mem_addr));
    endfunction

    // Model update on each rising edge
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                known      = 1'b1;
                clear_left = DEPTH / 4;
                for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h0;
                m_rd = 32'h0;
                m_wr = 32'h0;
            end else if (known) begin
                if (clear_left > 0) begin
                    clear_left--;
                end else begin
                    if (m_wr_ok()) begin
                        for (int k = 0; k < 4; k++) m_mem[int'(mem_addr) + k] = mem_data[8*k +: 8];
                        if (m_wr != 32'hFFFF_FFFF) m_wr++;
                    end
                    if (m_rd_ok() && (m_rd != 32'hFFFF_FFFF)) m_rd++;
                end
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (known) begin
                check("valM_o", valM_o, m_rd_ok() ? m_word(mem_addr) : 32'h0);
                check("dmem_error", {31'b0, dmem_error}, {31'b0, m_err()});
                check("busy", {31'b0, busy}, {31'b0, clear_left > 0});
                check("rd_count", rd_count, m_rd);
                check("wr_count", wr_count, m_wr);
            end
        end
    end

    task automatic set_idle();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = 32'h0;
        mem_data  = 32'h0;
    endtask

    // One access cycle; samples the combinational outputs mid-cycle
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] v, output logic e);
        mem_read  = rd;
        mem_write = wr;
        mem_addr  = a;
        mem_data  = d;
        @(negedge clk);
        v = valM_o;
        e = dmem_error;
        @(posedge clk);
        #1;
        set_idle();
    endtask

    // Pulse reset for one cycle and count cycles until busy drops (bounded)
    task automatic reset_and_wait(output int n);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n = 0;
        while ((busy === 1'b1) && (n < 400)) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [31:0] v;
        logic        e;
        logic [31:0] wr_before;

        rst = 1'b1;
        set_idle();

        // Power-up clear
        reset_and_wait(n);
        check("busy_cycles_first", 32'(n), 32'd256);
        check("rd_count_after_clear", rd_count, 32'd0);
        check("wr_count_after_clear", wr_count, 32'd0);

        // Little-endian write/read
        access(1'b0, 1'b1, 32'h100, 32'h1122_3344, v, e);
        check("wr_0x100_err", {31'b0, e}, 32'd0);
        access(1'b1, 1'b0, 32'h100, 32'h0, v, e);
        check("rd_0x100", v, 32'h1122_3344);
        access(1'b1, 1'b0, 32'h101, 32'h0, v, e);
`ifdef DMEM_ALIGN_CHECK_EN
        check("rd_0x101_err", {31'b0, e}, 32'd1);
        check("rd_0x101_val", v, 32'h0);
        check("rd_count_le", rd_count, 32'd1);
`else
        check("rd_0x101", v, 32'h0011_2233);
        check("rd_count_le", rd_count, 32'd2);
`endif
        check("wr_count_le", wr_count, 32'd1);

        // Cleared memory reads zero at both ends
        access(1'b1, 1'b0, 32'h000, 32'h0, v, e);
        check("rd_0x000", v, 32'h0);
        access(1'b1, 1'b0, 32'h3FC, 32'h0, v, e);
        check("rd_0x3FC_val", v, 32'h0);
        check("rd_0x3FC_err", {31'b0, e}, 32'd0);

        // Bounds
        access(1'b1, 1'b0, 32'h3FD, 32'h0, v, e);
        check("rd_0x3FD_err", {31'b0, e}, 32'd1);
        check("rd_0x3FD_val", v, 32'h0);
        wr_before = wr_count;
        access(1'b0, 1'b1, 32'hFFFF_FFFE, 32'hCAFE_F00D, v, e);
        check("wr_top_err", {31'b0, e}, 32'd1);
        check("wr_top_count", wr_count, wr_before);
        access(1'b1, 1'b0, 32'h000, 32'h0, v, e);
        check("rd_0x000_after_bad_wr", v, 32'h0);

        // Read/write conflict is rejected and leaves memory alone
        access(1'b1, 1'b1, 32'h020, 32'h1234_5678, v, e);
        check("conflict_err", {31'b0, e}, 32'd1);
        access(1'b1, 1'b0, 32'h020, 32'h0, v, e);
        check("rd_0x020_after_conflict", v, 32'h0);

        // Top word write/read
        access(1'b0, 1'b1, 32'h3FC, 32'h5566_7788, v, e);
        access(1'b1, 1'b0, 32'h3FC, 32'h0, v, e);
        check("rd_0x3FC_data", v, 32'h5566_7788);

`ifndef DMEM_ALIGN_CHECK_EN
        // Unaligned store straddling a word boundary
        access(1'b0, 1'b1, 32'h0FE, 32'hA1B2_C3D4, v, e);
        access(1'b1, 1'b0, 32'h100, 32'h0, v, e);
        check("rd_0x100_straddle", v, 32'h1122_A1B2);
        access(1'b1, 1'b0, 32'h0FC, 32'h0, v, e);
        check("rd_0x0FC_straddle", v, 32'hC3D4_0000);
`endif

        // Reset mid-clear; requests during CLEAR are ignored
        access(1'b0, 1'b1, 32'h200, 32'hDEAD_BEEF, v, e);
        access(1'b0, 1'b1, 32'h040, 32'h0BAD_0BAD, v, e);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            mem_read  = (i < 50);
            mem_write = 1'b1;
            mem_addr  = (i < 50) ? 32'h020 : 32'h040;
            mem_data  = 32'h7777_7777;
            @(negedge clk);
            if (i == 10) check("conflict_in_clear_err", {31'b0, dmem_error}, 32'd0);
            if (i == 60) check("write_in_clear_err", {31'b0, dmem_error}, 32'd0);
            @(posedge clk);
            #1;
        end
        set_idle();
        check("busy_mid_clear", {31'b0, busy}, 32'd1);
        check("wr_count_mid_clear", wr_count, 32'd0);
        reset_and_wait(n);
        check("busy_cycles_second", 32'(n), 32'd256);
        access(1'b1, 1'b0, 32'h200, 32'h0, v, e);
        check("rd_0x200_after_reset", v, 32'h0);
        access(1'b1, 1'b0, 32'h040, 32'h0, v, e);
        check("rd_0x040_after_reset", v, 32'h0);
        check("rd_count_after_reset", rd_count, 32'd2);
        check("wr_count_after_reset", wr_count, 32'd0);

`ifdef DMEM_ALIGN_CHECK_EN
        access(1'b0, 1'b1, 32'h102, 32'h0102_0304, v, e);
        check("align_wr_0x102_err", {31'b0, e}, 32'd1);
        check("align_wr_0x102_count", wr_count, 32'd0);
        access(1'b0, 1'b1, 32'h104, 32'h0506_0708, v, e);
        check("align_wr_0x104_err", {31'b0, e}, 32'd0);
        check("align_wr_0x104_count", wr_count, 32'd1);
`endif

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
